ram_seq_ctrl: RTL
=================

# ram_seq_ctrl

Sequencing controller for the game's 32x4 synchronous sequence RAM (registered address, combinational read of the latched address, synchronous write). It does three jobs on the single RAM port:
- plays back the stored sequence onto the LEDs with timed on/off gaps;
- checks player button presses against the stored entries;
- appends one new entry after a fully correct round.

It sits between the game FSM (commands, status) and the RAM.

## Interface
Parameters:
- ON_CYCLES, 1000: LED on-time per played entry, in clock cycles (≥1).
- GAP_CYCLES, 500: LED-off gap after each played entry (≥1).
- TIMEOUT_CYCLES, 5000: check/append inactivity limit (only with the macro).

Ports:
- clk, in, 1: single clock; all state changes on rising edge.
- reset, in, 1: synchronous, active-high.
- play_start, in, 1: start playback of entries 0..limit.
- check_start, in, 1: start checking entries 0..limit.
- limit, in, 5: index of the last entry in the current round.
- btn_valid, in, 1: one-cycle pulse, player pressed a button.
- btn_data, in, 4: button code, valid with btn_valid.
- ram_q, in, 4: RAM read data.
- ram_addr, out, 5: RAM address (registered).
- ram_we, out, 1: RAM write enable (registered).
- ram_data, out, 4: RAM write data (registered).
- led_out, out, 4: code shown during playback, 0 otherwise.
- busy, out, 1: high in every state except IDLE.
- hit, out, 1: one-cycle pulse, whole round matched.
- miss, out, 1: one-cycle pulse, wrong entry (or timeout).
- done, out, 1: one-cycle pulse, playback finished or append written.
- full, out, 1: level, set when a round with limit=31 completes; cleared by reset or play_start.

## Operation
- Reset values (after the reset edge): state IDLE, idx=0, ram_addr=0, ram_we=0, ram_data=0, led_out=0, busy=0, hit=miss=done=full=0, timer=0.
- IDLE:
  - play_start → P_ADDR, idx=0.
  - Else check_start → C_PREP, idx=0. play_start wins when both are high.
  - Commands are ignored while busy.
  - btn_valid is ignored outside C_WAIT and A_WAIT.
- Playback:
  - P_ADDR: ram_addr=idx, held for 1 cycle so the RAM latches it.
  - P_SHOW: led_out=ram_q for ON_CYCLES.
  - P_GAP: led_out=0 for GAP_CYCLES. Then, if idx==limit → done pulse, IDLE; else idx+1 → P_ADDR.
- Check:
  - C_PREP: ram_addr=idx for 1 cycle.
  - C_WAIT: waits for btn_valid, then compares btn_data with ram_q.
    - Mismatch → miss, IDLE.
    - Match with idx<limit → idx+1 → C_PREP.
    - Match with idx==limit → hit. Then go to A_WAIT, or, if limit==31, set full and go to IDLE with no append.
- Append:
  - A_WAIT: waits for btn_valid.
  - A_WR: ram_we=1, ram_addr=limit+1, ram_data=btn_data for exactly 1 cycle. Then done pulse, IDLE.
- Index arithmetic: idx is 5-bit. limit+1 is computed only when limit<31, so no wrap-around is possible.
- Reset mid-operation aborts immediately. ram_we is 0 from the reset edge, so no partial write occurs. No status pulse is emitted.
- The limit input is sampled only at command start; later changes are ignored until IDLE.

## Timing
- All outputs are registered.
- RAM read latency as seen by the controller: address presented in state S, ram_q valid in the next state.
- Check: hit/miss are high in the cycle after the edge that sampled btn_valid. The next press is accepted 2 cycles after a matching press.
- Playback total: (limit+1)·(1+ON_CYCLES+GAP_CYCLES) cycles from play_start to the done pulse.
- led_out rises on the edge entering P_SHOW and falls on the edge entering P_GAP.
- Append: ram_we is high in the cycle after A_WAIT samples btn_valid; done is high in the cycle after that.
- busy falls on the same edge that raises done, hit (with full), or miss, i.e. on the edge entering IDLE.

## Configuration
- RAM_SEQ_CTRL_TIMEOUT_EN defined: C_WAIT and A_WAIT count idle cycles. When TIMEOUT_CYCLES is reached without btn_valid → miss pulse, IDLE. The counter restarts on every state entry.
- RAM_SEQ_CTRL_TIMEOUT_EN undefined: no counter; C_WAIT and A_WAIT wait indefinitely. The TIMEOUT_CYCLES parameter is unused.

## Structure
- Package ram_seq_ctrl_pkg holds:
  - state enum: IDLE, P_ADDR, P_SHOW, P_GAP, C_PREP, C_WAIT, A_WAIT, A_WR;
  - ADDR_W=5, DATA_W=4, LAST_IDX=31.
- Sub-module seq_timer: loadable down-counter with load value, a zero flag and clear. Shared by the playback on/gap timing and the optional timeout.

## Test plan
- RAM preloaded 3,1,4; limit=2; ON=4, GAP=2; play_start → led_out shows 3,1,4 for 4 cycles each with 2-cycle zero gaps; done exactly 21 cycles after start.
- check_start, limit=2, presses 3,1,4 → hit once, no miss; then press 9 → RAM[3]=9 via a single ram_we cycle; done pulses.
- check_start, presses 3 then 2 → miss the cycle after the second press; busy=0; no ram_we.
- limit=31 with all 32 entries matched → hit, full=1, no append write; the next play_start clears full.
- Reset asserted during P_SHOW and during A_WR → led_out=0, ram_we=0 after the edge; state IDLE; no done/hit/miss.
- With RAM_SEQ_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=10: check_start with no press → miss 10 cycles after entering C_WAIT. Without the macro: no miss after 1000 cycles.

Source files
------------

// File: rtl/ram_seq_ctrl_pkg.sv
// ram_seq_ctrl shared types and constants.
// State encoding, RAM geometry and timer sizing helper.
package ram_seq_ctrl_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 4;
   localparam int LAST_IDX = 31;

   typedef enum logic [2:0] {
      IDLE,
      P_ADDR,
      P_SHOW,
      P_GAP,
      C_PREP,
      C_WAIT,
      A_WAIT,
      A_WR
   } state_t;

   // Counter width able to hold the largest (count - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ram_seq_ctrl_timer.sv
// seq_timer: loadable down-counter with zero flag and clear.
// Shared by playback on/gap timing and the optional wait timeout.
module seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Count down to zero and hold; load/clear take priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: playback, check and append on a 32x4 sequence RAM.
// Define RAM_SEQ_CTRL_TIMEOUT_EN to abort idle waits with a miss.
module ram_seq_ctrl
   import ram_seq_ctrl_pkg::*;
#(
   parameter int ON_CYCLES      = 1000,
   parameter int GAP_CYCLES     = 500,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_start,
   input  logic              check_start,
   input  logic [ADDR_W-1:0] limit,
   input  logic              btn_valid,
   input  logic [DATA_W-1:0] btn_data,
   input  logic [DATA_W-1:0] ram_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] led_out,
   output logic              busy,
   output logic              hit,
   output logic              miss,
   output logic              done,
   output logic              full
);

   localparam int CW =
      cnt_width(ON_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

   state_t            state, state_n;
   logic [ADDR_W-1:0] idx, idx_n;
   logic [ADDR_W-1:0] lim, lim_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] data_n, led_n;
   logic              we_n, hit_n, miss_n;
   logic              done_n, full_n;
   logic              t_clr, t_load, t_zero;
   logic [CW-1:0]     t_val;

   seq_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (t_clr),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         lim      <= '0;
         ram_addr <= '0;
         ram_we   <= 1'b0;
         ram_data <= '0;
         led_out  <= '0;
         busy     <= 1'b0;
         hit      <= 1'b0;
         miss     <= 1'b0;
         done     <= 1'b0;
         full     <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         lim      <= lim_n;
         ram_addr <= addr_n;
         ram_we   <= we_n;
         ram_data <= data_n;
         led_out  <= led_n;
         busy     <= (state_n != IDLE);
         hit      <= hit_n;
         miss     <= miss_n;
         done     <= done_n;
         full     <= full_n;
      end
   end

   // Next state, next outputs and timer control.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      lim_n   = lim;
      addr_n  = ram_addr;
      we_n    = 1'b0;
      data_n  = ram_data;
      led_n   = led_out;
      hit_n   = 1'b0;
      miss_n  = 1'b0;
      done_n  = 1'b0;
      full_n  = full;
      t_clr   = 1'b0;
      t_load  = 1'b0;
      t_val   = '0;
      unique case (state)
         IDLE: begin
            t_clr = 1'b1;
            if (play_start) begin
               state_n = P_ADDR;
               idx_n   = '0;
               lim_n   = limit;
               addr_n  = '0;
               full_n  = 1'b0;
            end else if (check_start) begin
               state_n = C_PREP;
               idx_n   = '0;
               lim_n   = limit;
               addr_n  = '0;
            end
         end
         P_ADDR: begin
            state_n = P_SHOW;
            led_n   = ram_q;
            t_load  = 1'b1;
            t_val   = CW'(ON_CYCLES - 1);
         end
         P_SHOW: begin
            if (t_zero) begin
               state_n = P_GAP;
               led_n   = '0;
               t_load  = 1'b1;
               t_val   = CW'(GAP_CYCLES - 1);
            end
         end
         P_GAP: begin
            if (t_zero) begin
               if (idx == lim) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = P_ADDR;
                  idx_n   = idx + ADDR_W'(1);
                  addr_n  = idx + ADDR_W'(1);
               end
            end
         end
         C_PREP: begin
            state_n = C_WAIT;
`ifdef RAM_SEQ_CTRL_TIMEOUT_EN
            t_load  = 1'b1;
            t_val   = CW'(TIMEOUT_CYCLES - 1);
`endif
         end
         C_WAIT: begin
            if (btn_valid) begin
               if (btn_data != ram_q) begin
                  state_n = IDLE;
                  miss_n  = 1'b1;
               end else if (idx != lim) begin
                  state_n = C_PREP;
                  idx_n   = idx + ADDR_W'(1);
                  addr_n  = idx + ADDR_W'(1);
               end else begin
                  hit_n = 1'b1;
                  if (lim == ADDR_W'(LAST_IDX)) begin
                     state_n = IDLE;
                     full_n  = 1'b1;
                  end else begin
                     state_n = A_WAIT;
`ifdef RAM_SEQ_CTRL_TIMEOUT_EN
                     t_load  = 1'b1;
                     t_val   = CW'(TIMEOUT_CYCLES - 1);
`endif
                  end
               end
            end
`ifdef RAM_SEQ_CTRL_TIMEOUT_EN
            else if (t_zero) begin
               state_n = IDLE;
               miss_n  = 1'b1;
            end
`endif
         end
         A_WAIT: begin
            if (btn_valid) begin
               state_n = A_WR;
               we_n    = 1'b1;
               addr_n  = lim + ADDR_W'(1);
               data_n  = btn_data;
            end
`ifdef RAM_SEQ_CTRL_TIMEOUT_EN
            else if (t_zero) begin
               state_n = IDLE;
               miss_n  = 1'b1;
            end
`endif
         end
         A_WR: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
